// File: rtl/hex_serial_adder_pkg.sv
// Shared definitions for the digit-serial hex add/subtract unit.
// State encoding and nibble width are used by both the top level and its bench.
package hex_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hex_serial_adder_if.sv
// Operand/result handshake bundle for hex_serial_adder.
// The master issues operands and drains results; the slave is the adder.
interface hex_serial_adder_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output op_valid, a_in, b_in, cin, sub, res_ready,
    input  op_ready, res_valid, result, cout, ovf
  );

  modport slave (
    input  op_valid, a_in, b_in, cin, sub, res_ready,
    output op_ready, res_valid, result, cout, ovf
  );

endinterface

// File: rtl/hex_serial_adder_hex_adder.sv
// HexAdder: 4-bit ripple adder shared by the serial unit, one nibble per call.
// Computes {Cout, Sum} = A + B + C.
module HexAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C,
  output logic [3:0] Sum,
  output logic       Cout
);

  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, C};

endmodule

// File: rtl/hex_serial_adder.sv
// Digit-serial hex add/subtract: streams one nibble per clock through HexAdder,
// LSD first, holding the inter-digit carry in a flop and assembling the result.
module hex_serial_adder
  import hex_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   abort,
  hex_serial_adder_if.slave      bus
);

  localparam int W  = NIBBLE_W * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t               state;
  logic [CW-1:0]        digit;
  logic                 carry;
  logic [W-1:0]         a_reg;
  logic [W-1:0]         b_reg;
  logic [W-1:0]         result_q;
  logic                 cout_q;
  logic                 ovf_q;
  logic                 res_valid_q;

  logic [NIBBLE_W-1:0]  a_nib;
  logic [NIBBLE_W-1:0]  b_nib;
  logic [NIBBLE_W-1:0]  sum_nib;
  logic                 cout_nib;
  logic                 carry_into_msb;

  assign a_nib = a_reg[digit*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_reg[digit*NIBBLE_W +: NIBBLE_W];

  HexAdder u_hex_adder (
    .A    (a_nib),
    .B    (b_nib),
    .C    (carry),
    .Sum  (sum_nib),
    .Cout (cout_nib)
  );

  // Signed overflow needs the carry into the sign bit of the top nibble.
  assign carry_into_msb = a_nib[3] ^ b_nib[3] ^ sum_nib[3];

  assign bus.op_ready  = (state == IDLE) && rst_n;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      digit       <= '0;
      carry       <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      digit       <= '0;
      carry       <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            // Subtraction is A + ~B + 1, so the incoming carry is forced high.
            a_reg    <= bus.a_in;
            b_reg    <= bus.sub ? ~bus.b_in : bus.b_in;
            carry    <= bus.sub ? 1'b1 : bus.cin;
            digit    <= '0;
            result_q <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          result_q[digit*NIBBLE_W +: NIBBLE_W] <= sum_nib;
          carry <= cout_nib;
          if (digit == LAST) begin
            cout_q      <= cout_nib;
            ovf_q       <= carry_into_msb ^ cout_nib;
            digit       <= '0;
            res_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            digit <= digit + 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_serial_adder.sv
// Directed self-checking bench for hex_serial_adder (DIGITS = 4).
// Drives on posedge+1 and samples there, away from the active edge.
module tb_hex_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;

  int assertCount = 0;
  int failCount   = 0;

  hex_serial_adder_if #(.DIGITS(4)) bus ();

  hex_serial_adder #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (abort),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s);
    int guard = 0;
    bus.a_in = a;
    bus.b_in = b;
    bus.cin  = c;
    bus.sub  = s;
    while (!bus.op_ready && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput({tag, " op_ready"}, 32'(bus.op_ready), 32'd1);
    bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [15:0] expRes,
                            input logic expCout, input logic expOvf);
    int cycles = 0;
    while (!bus.res_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'd4);
    checkOutput({tag, " result"}, 32'(bus.result), 32'(expRes));
    checkOutput({tag, " cout"}, 32'(bus.cout), 32'(expCout));
    checkOutput({tag, " ovf"}, 32'(bus.ovf), 32'(expOvf));
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checkOutput({tag, " res_valid drop"}, 32'(bus.res_valid), 32'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic c, input logic s, input logic [15:0] expRes,
                               input logic expCout, input logic expOvf);
    startOp(tag, a, b, c, s);
    waitResult(tag, expRes, expCout, expOvf);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;

    #1;
    checkOutput("reset op_ready", 32'(bus.op_ready), 32'd0);
    checkOutput("reset res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("reset result", 32'(bus.result), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset op_ready", 32'(bus.op_ready), 32'd1);

    applyStimulus("add basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    applyStimulus("add ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("add cin",     16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("add ovf pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    applyStimulus("sub 7-5",     16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    applyStimulus("sub 7-5 cin", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    applyStimulus("sub 5-7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    applyStimulus("sub ovf",     16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Abort one digit into RUN: everything clears and no result appears.
    startOp("abort", 16'h1234, 16'h4321, 1'b0, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort op_ready", 32'(bus.op_ready), 32'd1);
    checkOutput("abort result", 32'(bus.result), 32'd0);
    checkOutput("abort cout", 32'(bus.cout), 32'd0);
    checkOutput("abort ovf", 32'(bus.ovf), 32'd0);
    seen = 0;
    repeat (8) begin
      tick();
      if (bus.res_valid) seen++;
    end
    checkOutput("abort no res_valid", 32'(seen), 32'd0);

    applyStimulus("add ovf neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Asynchronous reset after two digits have been processed.
    startOp("midreset", 16'h1234, 16'h4321, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("midreset partial", 32'(bus.result), 32'h0055);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset result", 32'(bus.result), 32'd0);
    checkOutput("midreset cout", 32'(bus.cout), 32'd0);
    checkOutput("midreset ovf", 32'(bus.ovf), 32'd0);
    checkOutput("midreset res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("midreset op_ready", 32'(bus.op_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus("after reset", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    // Backpressure: result held in DONE while a new op is offered.
    startOp("bp", 16'h0F0F, 16'h0101, 1'b0, 1'b0);
    seen = 0;
    while (!bus.res_valid && seen < 20) begin
      tick();
      seen++;
    end
    checkOutput("bp latency", 32'(seen), 32'd4);
    bus.a_in     = 16'h1111;
    bus.b_in     = 16'h1111;
    bus.op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp result held", 32'(bus.result), 32'h1010);
      checkOutput("bp op_ready low", 32'(bus.op_ready), 32'd0);
      checkOutput("bp res_valid held", 32'(bus.res_valid), 32'd1);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checkOutput("bp release res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("bp release op_ready", 32'(bus.op_ready), 32'd1);
    tick();
    bus.op_valid = 1'b0;
    checkOutput("bp new op accepted", 32'(bus.op_ready), 32'd0);
    waitResult("bp new op", 16'h2222, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
